lsu_mem_ctrl: RTL and testbench

Sequencing controller between the core's load/store stage and the single-ported data-memory bus. It accepts one load or store per request, drives byte-lane masks and lane-aligned write data, and splits misaligned halfword and word accesses into two aligned bus beats. For loads, it reassembles the returned bytes and sign- or zero-extends them. It keeps at most one bus transaction outstanding and returns a single-cycle response to the core.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 31 +++
 rtl/lsu_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory controller.
// Holds size/state encodings, the byte-lane base mask and load extension.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  function automatic logic [3:0] base_mask(size_e sz);
    case (sz)
      SZ_B:    base_mask = 4'b0001;
      SZ_H:    base_mask = 4'b0011;
      SZ_W:    base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extend(logic [31:0] v, size_e sz, logic uns);
    case (sz)
      SZ_B:    extend = {{24{~uns & v[7]}}, v[7:0]};
      SZ_H:    extend = {{16{~uns & v[15]}}, v[15:0]};
      SZ_W:    extend = v;
      default: extend = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store mask/data across two word beats,
// and load reassembly from the two-beat buffer with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rbuf,
  input  logic        uns,
  output logic [7:0]  m8,
  output logic [63:0] d64,
  output logic [31:0] rdata
);

  logic [63:0] wshift;
  logic [63:0] rshift;

  always_comb begin
    m8     = {4'b0000, base_mask(size_e'(size))} << off;
    wshift = {32'h0, wdata} << {off, 3'b000};
    d64    = 64'h0;
    // Lanes outside the access are forced to zero on the bus.
    for (int i = 0; i < 8; i++) begin
      if (m8[i]) d64[8*i +: 8] = wshift[8*i +: 8];
    end
    rshift = rbuf >> {off, 3'b000};
    rdata  = extend(rshift[31:0], size_e'(size), uns);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer onto a single-ported data bus; splits misaligned
// accesses into two aligned beats, one bus transaction outstanding at a time.
module lsu_mem_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_nxt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [63:0] buf_q;

  logic [7:0]  m8;
  logic [63:0] d64;
  logic [31:0] ld_rdata;
  logic        split;

  lsu_lane_align u_align (
    .size  (size_q),
    .off   (addr_q[1:0]),
    .wdata (wdata_q),
    .rbuf  (buf_q),
    .uns   (uns_q),
    .m8    (m8),
    .d64   (d64),
    .rdata (ld_rdata)
  );

  assign split = |m8[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      buf_q   <= 64'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        err_q   <= (req_size == SZ_ILL);
      end
      if (state == WAIT0 && mem_rvalid) buf_q[31:0]  <= mem_rdata;
      if (state == WAIT1 && mem_rvalid) buf_q[63:32] <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE) && !rst;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wmask = 4'b0000;
    mem_wdata = 32'h0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;

    case (state)
      IDLE: begin
        if (req_valid) state_nxt = (req_size == SZ_ILL) ? RESP : REQ0;
      end
      REQ0, REQ1: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        // Beat 1 targets the next word; the add wraps at the top of memory.
        mem_addr = {addr_q[31:2], 2'b00} + ((state == REQ1) ? 32'd4 : 32'd0);
        if (we_q) begin
          mem_wmask = (state == REQ1) ? m8[7:4]     : m8[3:0];
          mem_wdata = (state == REQ1) ? d64[63:32] : d64[31:0];
        end
        if (mem_gnt) begin
          if (!we_q)                          state_nxt = (state == REQ0) ? WAIT0 : WAIT1;
          else if (state == REQ0 && split)    state_nxt = REQ1;
          else                                state_nxt = RESP;
        end
      end
      WAIT0: begin
        if (mem_rvalid) state_nxt = split ? REQ1 : RESP;
      end
      WAIT1: begin
        if (mem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || we_q) ? 32'h0 : ld_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected beats and
// responses; independent monitors compare bus beats and core responses.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } rsp_t;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rd_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int gnt_wait = 0;
  bit manual = 1'b0;
  logic        man_gnt = 1'b0;
  logic        man_rv  = 1'b0;
  logic [31:0] man_rd  = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic w, input logic [3:0] m,
                           input logic [31:0] d);
    beat_t b;
    b.addr = a; b.we = w; b.mask = m; b.wdata = d;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int   guard;
    rsp_t e;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    e.rdata = exp_rd; e.err = exp_err; e.at = cyc + lat;
    rsp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (rsp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (rsp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: got none expected rsp_valid by cycle %0d", e.at);
      rsp_q.delete(); beat_q.delete(); rd_q.delete();
    end
  endtask

  // Bus responder: grants after gnt_wait cycles, read data one cycle after grant.
  initial begin
    int wcnt;
    bit rvp;
    wcnt = 0; rvp = 1'b0;
    forever begin
      @(negedge clk);
      if (manual) begin
        mem_gnt = man_gnt; mem_rvalid = man_rv; mem_rdata = man_rd;
        wcnt = 0; rvp = 1'b0;
      end else begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        if (rvp) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEADDEAD;
          rvp = 1'b0;
        end
        if (mem_req) begin
          if (wcnt < gnt_wait) wcnt++;
          else begin
            mem_gnt = 1'b1;
            wcnt = 0;
            if (!mem_we) rvp = 1'b1;
          end
        end
      end
    end
  end

  // Beat monitor: every cycle of a request must match the head beat (stability).
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (beat_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got addr %h expected no mem_req", mem_addr);
        end else begin
          check("beat_addr", mem_addr, beat_q[0].addr);
          check("beat_we", 32'(mem_we), 32'(beat_q[0].we));
          check("beat_mask", 32'(mem_wmask), 32'(beat_q[0].mask));
          check("beat_wdata", mem_wdata, beat_q[0].wdata);
          check("ready_busy", 32'(req_ready), 32'h0);
          if (mem_gnt) void'(beat_q.pop_front());
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got rdata %h expected no rsp_valid", rsp_rdata);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(e.at));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("ready_after_rst", 32'(req_ready), 32'h1);

    // Aligned word load.
    push_beat(32'h100, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h8899AABB);
    issue(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'h8899AABB, 1'b0, 3);
    // Byte load at offset 3, signed then unsigned.
    push_beat(32'h100, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h80000000);
    issue(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    push_beat(32'h100, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'h80000000);
    issue(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, 3);
    // Aligned half load, unsigned.
    push_beat(32'h100, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'hF00D0000);
    issue(1'b0, 32'h102, 2'b01, 1'b1, 32'h0, 32'h0000F00D, 1'b0, 3);
    // Split word store.
    push_beat(32'h104, 1'b1, 4'b1100, 32'h33440000);
    push_beat(32'h108, 1'b1, 4'b0011, 32'h00001122);
    issue(1'b1, 32'h106, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 3);
    // Split half store at offset 3.
    push_beat(32'h40, 1'b1, 4'b1000, 32'hEF000000);
    push_beat(32'h44, 1'b1, 4'b0001, 32'h000000BE);
    issue(1'b1, 32'h43, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, 1'b0, 3);
    // Split signed half load wrapping the address space.
    push_beat(32'hFFFFFFFC, 1'b0, 4'b0000, 32'h0);
    push_beat(32'h00000000, 1'b0, 4'b0000, 32'h0);
    rd_q.push_back(32'hAB000000); rd_q.push_back(32'h000000CD);
    issue(1'b0, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0, 32'hFFFFCDAB, 1'b0, 5);
    // Split word load at offset 1.
    push_beat(32'h100, 1'b0, 4'b0000, 32'h0);
    push_beat(32'h104, 1'b0, 4'b0000, 32'h0);
    rd_q.push_back(32'h44332211); rd_q.push_back(32'h88776655);
    issue(1'b0, 32'h101, 2'b10, 1'b0, 32'h0, 32'h55443322, 1'b0, 5);
    // Aligned word store.
    push_beat(32'h20, 1'b1, 4'b1111, 32'hDEADBEEF);
    issue(1'b1, 32'h20, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    // Byte store with three grant-wait cycles; upper wdata bytes must not leak.
    gnt_wait = 3;
    push_beat(32'h40, 1'b1, 4'b0010, 32'h00005A00);
    issue(1'b1, 32'h41, 2'b00, 1'b0, 32'h1234565A, 32'h0, 1'b0, 5);
    gnt_wait = 0;
    // Illegal size: immediate error response, no bus beat.
    issue(1'b0, 32'h200, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 32'h204, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1);

    // Reset while waiting for read data; the late rvalid must be dropped.
    manual = 1'b1;
    push_beat(32'h300, 1'b0, 4'b0000, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_size = 2'b10;
    req_unsigned = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0; man_gnt = 1'b1;
    @(posedge clk); #2;
    man_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; man_rv = 1'b1; man_rd = 32'h12345678;
    @(negedge clk); #1;
    check("reset_idle_ready", 32'(req_ready), 32'h1);
    check("reset_idle_mem_req", 32'(mem_req), 32'h0);
    @(posedge clk); #2;
    man_rv = 1'b0; man_rd = 32'h0;
    repeat (6) @(negedge clk);
    #2;
    check("reset_no_rsp", 32'(rsp_q.size()), 32'h0);
    check("reset_beats_done", 32'(beat_q.size()), 32'h0);
    manual = 1'b0;

    // Normal operation after the abandoned transaction.
    push_beat(32'h400, 1'b0, 4'b0000, 32'h0); rd_q.push_back(32'hCAFEF00D);
    issue(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
